// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BIN_W_DEF  = 20;
  localparam int unsigned DIGITS_DEF = 6;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // 10^n as a 64-bit constant, used for the out-of-range compare
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the nibble is 5 or more.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj_c
);

  assign adj_c = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Optional leading-zero blanking is enabled with macro BCD_LEADING_BLANK_EN.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned ACC_W = BCD_W + 4;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS);

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   sr;
  logic [BIN_W-1:0]   cap;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               spill;
  logic               load_c;
  logic               shift_c;
  logic               finish_c;
  logic               last_c;
  logic               ovf_c;
  logic [BCD_W-1:0]   digits_c;

  // One corrector per accumulator nibble, including the overflow nibble
  for (genvar g = 0; g < int'(DIGITS) + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib   (acc[4*g +: 4]),
      .adj_c (acc_adj[4*g +: 4])
    );
  end

  assign last_c = (cnt == CNT_W'(BIN_W - 1));

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        shift_c = 1'b1;
        if (last_c) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        finish_c  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Out of range if anything landed in or beyond the spare nibble, or the raw value is too big
  assign ovf_c = spill || (acc[ACC_W-1 -: 4] != 4'd0) || (64'(cap) >= LIMIT);

  // Result digits: optional leading-zero blanking, all blank on overflow
  always_comb begin
`ifdef BCD_LEADING_BLANK_EN
    logic lead;
    lead     = 1'b1;
    digits_c = acc[BCD_W-1:0];
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (lead && (digits_c[4*i +: 4] == 4'd0)) begin
        digits_c[4*i +: 4] = BLANK;
      end else begin
        lead = 1'b0;
      end
    end
`else
    digits_c = acc[BCD_W-1:0];
`endif
    if (ovf_c) begin
      digits_c = {DIGITS{BLANK}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cap   <= '0;
      acc   <= '0;
      cnt   <= '0;
      spill <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      bcd   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= finish_c;
      if (load_c) begin
        sr    <= bin;
        cap   <= bin;
        acc   <= '0;
        cnt   <= '0;
        spill <= 1'b0;
      end else if (shift_c) begin
        acc   <= {acc_adj[ACC_W-2:0], sr[BIN_W-1]};
        sr    <= {sr[BIN_W-2:0], 1'b0};
        cnt   <= cnt + CNT_W'(1);
        spill <= spill | acc_adj[ACC_W-1];
      end
      if (finish_c) begin
        bcd <= digits_c;
        ovf <= ovf_c;
      end
    end
  end

endmodule
